pwm_multi_ch: RTL and testbench

Parametrised multi-channel PWM generator. It succeeds the single-channel tt_um PWM top and is instantiated inside the next tt_um wrapper. CHANNELS outputs share one prescaler and one period counter. Each channel has its own duty register. Edge-aligned or center-aligned mode is selectable, and all configuration is double-buffered so that it takes effect only at a period boundary.

---
 rtl/pwm_multi_ch.sv | 122 ++++++++++++
 tb/tb_pwm_multi_ch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel duty,
// edge or center alignment, all configuration double-buffered to the period boundary.
module pwm_multi_ch #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WIDTH-1:0]    cfg_wdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick,
    output logic [WIDTH-1:0]    cnt_out
);

    // Pending (written by config port) and active (used by the counter) copies.
    logic [WIDTH-1:0]    r_top_p, r_pre_p, r_top_a, r_pre_a;
    logic                r_mode_p, r_mode_a;
    logic [WIDTH-1:0]    r_duty_p [CHANNELS];
    logic [WIDTH-1:0]    r_duty_a [CHANNELS];

    logic [WIDTH-1:0]    r_psc;
    logic [WIDTH-1:0]    r_cnt;
    logic                r_down;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_tick;

    logic                w_adv;
    logic                w_bnd;
    logic                w_bnd_edge;
    logic                w_bnd_center;

    assign w_adv        = ena && (r_psc == r_pre_a);
    assign w_bnd_edge   = (r_cnt == r_top_a);
    // Center mode normally ends on the way down at 1; TOP of 0 or 1 never turns around.
    assign w_bnd_center = r_down ? (r_cnt == WIDTH'(1))
                                 : ((r_cnt == r_top_a) && (r_top_a <= WIDTH'(1)));
    assign w_bnd        = w_adv && (r_mode_a ? w_bnd_center : w_bnd_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_p  <= '0;
            r_pre_p  <= '0;
            r_mode_p <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) r_duty_p[ch] <= '0;
        end else if (cfg_we) begin
            if (cfg_addr == ADDR_W'(0)) r_top_p  <= cfg_wdata;
            if (cfg_addr == ADDR_W'(1)) r_pre_p  <= cfg_wdata;
            if (cfg_addr == ADDR_W'(2)) r_mode_p <= cfg_wdata[0];
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (cfg_addr == ADDR_W'(ch + 3)) r_duty_p[ch] <= cfg_wdata;
            end
        end
    end

    // Active copies see the pending values from before any write on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top_a  <= '0;
            r_pre_a  <= '0;
            r_mode_a <= 1'b0;
            for (int ch = 0; ch < CHANNELS; ch++) r_duty_a[ch] <= '0;
        end else if (w_bnd) begin
            r_top_a  <= r_top_p;
            r_pre_a  <= r_pre_p;
            r_mode_a <= r_mode_p;
            for (int ch = 0; ch < CHANNELS; ch++) r_duty_a[ch] <= r_duty_p[ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psc <= '0;
        end else if (ena) begin
            r_psc <= w_adv ? '0 : r_psc + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_down <= 1'b0;
        end else if (w_bnd) begin
            r_cnt  <= '0;
            r_down <= 1'b0;
        end else if (w_adv) begin
            if (!r_mode_a) begin
                r_cnt <= r_cnt + WIDTH'(1);
            end else if (r_down) begin
                r_cnt <= r_cnt - WIDTH'(1);
            end else if (r_cnt == r_top_a) begin
                r_cnt  <= r_cnt - WIDTH'(1);
                r_down <= 1'b1;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    // Outputs only refresh while enabled so a freeze holds them exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_bnd;
            if (ena) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    r_pwm[ch] <= (r_cnt < r_duty_a[ch]);
                end
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;
    assign cnt_out     = r_cnt;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random config/enable traffic,
// checked every cycle against a period-position reference model.
module tb_pwm_multi_ch;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int ADDR_W   = 4;

    logic                clk;
    logic                rst_n;
    logic                ena;
    logic                cfg_we;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [WIDTH-1:0]    cfg_wdata;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_tick;
    logic [WIDTH-1:0]    cnt_out;

    pwm_multi_ch #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .cnt_out     (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tracks position within the period rather than a counter/direction pair.
    int             p_top, p_pre, p_mode;
    int             p_duty [CHANNELS];
    int             a_top, a_pre, a_mode;
    int             a_duty [CHANNELS];
    int             m_psc, m_pos;
    logic [CHANNELS-1:0] m_pwm;
    logic           m_tick;

    function automatic int m_period();
        if (a_mode == 0) return a_top + 1;
        return (a_top == 0) ? 1 : 2 * a_top;
    endfunction

    function automatic int m_cnt();
        if (a_mode == 0 || m_pos <= a_top) return m_pos;
        return 2 * a_top - m_pos;
    endfunction

    task automatic m_reset();
        p_top = 0; p_pre = 0; p_mode = 0;
        a_top = 0; a_pre = 0; a_mode = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            p_duty[c] = 0;
            a_duty[c] = 0;
        end
        m_psc = 0; m_pos = 0; m_pwm = '0; m_tick = 1'b0;
    endtask

    task automatic step(input logic en, input logic we, input int addr, input int data);
        logic adv;
        logic tick_n;
        ena       = en;
        cfg_we    = we;
        cfg_addr  = ADDR_W'(addr);
        cfg_wdata = WIDTH'(data);
        @(posedge clk);
        adv    = en && (m_psc == a_pre);
        tick_n = 1'b0;
        if (en) begin
            for (int c = 0; c < CHANNELS; c++) m_pwm[c] = (m_cnt() < a_duty[c]);
            m_psc = adv ? 0 : m_psc + 1;
        end
        if (adv) begin
            if (m_pos == m_period() - 1) begin
                m_pos  = 0;
                a_top  = p_top;
                a_pre  = p_pre;
                a_mode = p_mode;
                for (int c = 0; c < CHANNELS; c++) a_duty[c] = p_duty[c];
                tick_n = 1'b1;
            end else begin
                m_pos++;
            end
        end
        m_tick = tick_n;
        if (we) begin
            if (addr == 0) p_top = data % 256;
            else if (addr == 1) p_pre = data % 256;
            else if (addr == 2) p_mode = data % 2;
            else if (addr >= 3 && addr < 3 + CHANNELS) p_duty[addr - 3] = data % 256;
        end
        #1;
        check("cnt_out", 32'(cnt_out), 32'(m_cnt()));
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("period_tick", 32'(period_tick), 32'(m_tick));
    endtask

    task automatic wr(input int addr, input int data);
        step(1'b1, 1'b1, addr, data);
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step(en, 1'b0, 0, 0);
    endtask

    // Counts high cycles of one channel and ticks over a window of n enabled cycles.
    task automatic window(input int n, input int ch, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            run(1, 1'b1);
            if (pwm_out[ch]) highs++;
            if (period_tick) ticks++;
        end
    endtask

    int hi0, hi1, hi2, tk;

    initial begin
        rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_cnt", 32'(cnt_out), 32'd0);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Edge mode, TOP=9, duty 3 / 0 / 10.
        wr(0, 9); wr(1, 0); wr(2, 0); wr(3, 3); wr(4, 0); wr(5, 10);
        run(25, 1'b1);
        window(10, 0, hi0, tk);
        check("edge_duty3_highs", 32'(hi0), 32'd3);
        check("edge_ticks_per10", 32'(tk), 32'd1);
        window(10, 1, hi1, tk);
        check("edge_duty0_highs", 32'(hi1), 32'd0);
        window(10, 2, hi2, tk);
        check("edge_dutyover_highs", 32'(hi2), 32'd10);

        // Asynchronous reset while channel 2 is high, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_tick", 32'(period_tick), 32'd0);
        check("async_rst_cnt", 32'(cnt_out), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Center mode, TOP=4, duty 2.
        wr(2, 1); wr(0, 4); wr(3, 2);
        run(20, 1'b1);
        window(8, 0, hi0, tk);
        check("center_duty2_highs", 32'(hi0), 32'd3);
        check("center_ticks_per8", 32'(tk), 32'd1);

        // Duty change mid-period, then a write landing on the boundary cycle.
        wr(2, 0); wr(0, 9); wr(3, 3);
        run(25, 1'b1);
        for (int i = 0; i < 20 && m_cnt() != 4; i++) run(1, 1'b1);
        wr(3, 7);
        run(25, 1'b1);
        for (int i = 0; i < 20 && !(m_pos == m_period() - 1 && m_psc == a_pre); i++) run(1, 1'b1);
        wr(3, 5);
        run(25, 1'b1);

        // Prescale 3 and an enable freeze.
        wr(1, 3);
        run(60, 1'b1);
        window(40, 0, hi0, tk);
        check("presc_ticks_per40", 32'(tk), 32'd1);
        check("presc_highs_per40", 32'(hi0), 32'd20);
        run(6, 1'b1);
        run(10, 1'b0);
        run(30, 1'b1);

        // TOP=0 in both modes, plus an unmapped write.
        wr(1, 0); wr(0, 0); wr(3, 1);
        run(50, 1'b1);
        window(5, 0, hi0, tk);
        check("top0_edge_ticks", 32'(tk), 32'd5);
        check("top0_edge_highs", 32'(hi0), 32'd5);
        wr(2, 1);
        wr(CHANNELS + 3, 8'hff);
        run(5, 1'b1);
        window(5, 0, hi0, tk);
        check("top0_center_ticks", 32'(tk), 32'd5);
        check("top0_center_highs", 32'(hi0), 32'd5);

        // Random configuration and enable traffic, including unmapped addresses.
        for (int i = 0; i < 1500; i++) begin
            int   addr;
            int   data;
            logic en;
            logic we;
            en   = ($urandom_range(0, 9) != 0);
            we   = ($urandom_range(0, 3) == 0);
            addr = $urandom_range(0, 15);
            if (addr == 0) data = $urandom_range(0, 12);
            else if (addr == 1) data = $urandom_range(0, 2);
            else data = $urandom_range(0, 15);
            step(en, we, addr, data);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
